// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
// PERF_SNAPSHOT_EN adds per-counter snapshot shadows.
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_OFF    = 2'd0,
    PERF_LEVEL  = 2'd1,
    PERF_EDGE   = 2'd2,
    PERF_MAXRUN = 2'd3
  } perf_mode_e;

  localparam logic [1:0] SEL_CFG    = 2'd0;
  localparam logic [1:0] SEL_CNT_LO = 2'd1;
  localparam logic [1:0] SEL_CNT_HI = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_EN_BIT   = 2;
  localparam int CFG_IRQ_BIT  = 3;
  localparam int CFG_ESEL_LSB = 8;

  localparam logic [31:0] CFG_MASK = 32'h0000_FF0F;

  function automatic perf_mode_e cfg_mode(
    input logic [31:0] c
  );
    return perf_mode_e'(c[CFG_MODE_LSB+:2]);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One performance counter channel: config, count, run tracker, ovf.
// PERF_SNAPSHOT_EN adds a shadow copy loaded by snap.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        evt,
  input  logic        freeze,
  input  logic        snap,
  input  logic        cfg_we,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic        st_we,
  input  logic [31:0] wd,
  output logic [31:0] cfg,
  output logic [63:0] cnt_rd,
  output logic        ovf,
  output logic        irq_req
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] run_n;
  logic [CNT_W-1:0] lo_val;
  logic [CNT_W-1:0] hi_val;
  logic             prev;
  logic             wrap;
  logic             active;
  perf_mode_e       mode;

  assign mode   = cfg_mode(cfg);
  assign active = cfg[CFG_EN_BIT]
                & (mode != PERF_OFF)
                & ~freeze;

  // Preload merges one 32-bit half into the live count.
  if (CNT_W > 32) begin : g_wide
    assign lo_val = {cnt[CNT_W-1:32], wd};
    assign hi_val = {wd[CNT_W-33:0], cnt[31:0]};
  end else begin : g_narrow
    assign lo_val = wd[CNT_W-1:0];
    assign hi_val = cnt;
  end

  always_comb begin
    cnt_n = cnt;
    run_n = run;
    wrap  = 1'b0;
    if (active) begin
      unique case (1'b1)
        mode == PERF_LEVEL: begin
          if (evt) begin
            cnt_n = cnt + 1'b1;
            wrap  = (cnt == ONES);
          end
        end
        mode == PERF_EDGE: begin
          if (evt && !prev) begin
            cnt_n = cnt + 1'b1;
            wrap  = (cnt == ONES);
          end
        end
        mode == PERF_MAXRUN: begin
          if (evt) begin
            run_n = (run == ONES) ? ONES
                                  : run + 1'b1;
            if (run_n > cnt)
              cnt_n = run_n;
          end else begin
            run_n = '0;
          end
        end
        default: ;
      endcase
    end
    // A register write beats the same-cycle increment.
    if (lo_we) begin
      cnt_n = lo_val;
      wrap  = 1'b0;
    end
    if (hi_we) begin
      cnt_n = hi_val;
      wrap  = 1'b0;
    end
    if (cfg_we)
      run_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg  <= '0;
      cnt  <= '0;
      run  <= '0;
      prev <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      run  <= run_n;
      prev <= evt;
      if (cfg_we)
        cfg <= wd & CFG_MASK;
      if (wrap)
        ovf <= 1'b1;
      else if (st_we && wd[0])
        ovf <= 1'b0;
    end
  end

  assign irq_req = ovf & cfg[CFG_IRQ_BIT];

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset)
      shadow <= '0;
    else if (snap)
      shadow <= cnt_n;
  end

  assign cnt_rd = 64'(shadow);
`else
  logic unused_snap;

  assign unused_snap = snap;
  assign cnt_rd      = 64'(cnt);
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with a small register port and overflow irq.
// PERF_SNAPSHOT_EN makes count reads return snapshot shadows.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int NUM_EVT = 32,
  parameter int CNT_W   = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] events,
  input  logic               freeze,
  input  logic               snap,
  input  logic               we,
  input  logic               re,
  input  logic [5:0]         addr,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  output logic               irq
);

  logic [3:0]         idx;
  logic [1:0]         sel;
  logic [255:0]       evt_pad;
  logic [31:0]        cfg_a [NUM_CNT];
  logic [63:0]        cnt_a [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_v;
  logic [NUM_CNT-1:0] irq_v;
  logic [NUM_CNT-1:0] evt_v;
  logic [31:0]        c_cfg;
  logic [63:0]        c_cnt;
  logic               c_ovf;
  logic [31:0]        rd_n;

  assign idx = addr[5:2];
  assign sel = addr[1:0];

  // Unused select codes land on zero padding.
  assign evt_pad = 256'(events);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic hit;

    assign hit      = we && (idx == 4'(i));
    assign evt_v[i] = evt_pad[cfg_a[i][CFG_ESEL_LSB+:8]];

    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .evt     (evt_v[i]),
      .freeze  (freeze),
      .snap    (snap),
      .cfg_we  (hit && (sel == SEL_CFG)),
      .lo_we   (hit && (sel == SEL_CNT_LO)),
      .hi_we   (hit && (sel == SEL_CNT_HI)),
      .st_we   (hit && (sel == SEL_STATUS)),
      .wd      (wd),
      .cfg     (cfg_a[i]),
      .cnt_rd  (cnt_a[i]),
      .ovf     (ovf_v[i]),
      .irq_req (irq_v[i])
    );
  end

  always_comb begin
    c_cfg = '0;
    c_cnt = '0;
    c_ovf = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (idx == 4'(i)) begin
        c_cfg = cfg_a[i];
        c_cnt = cnt_a[i];
        c_ovf = ovf_v[i];
      end
    end
    rd_n = '0;
    unique case (1'b1)
      sel == SEL_CFG:    rd_n = c_cfg;
      sel == SEL_CNT_LO: rd_n = c_cnt[31:0];
      sel == SEL_CNT_HI: rd_n = c_cnt[63:32];
      sel == SEL_STATUS: rd_n = {31'd0, c_ovf};
      default:           rd_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd  <= '0;
      irq <= 1'b0;
    end else begin
      if (re)
        rd <= rd_n;
      irq <= |irq_v;
    end
  end

endmodule
